// File: rtl/seq_detector_param.sv
// Programmable serial sequence detector: runtime pattern,
// overlap/non-overlap mode and a saturating match counter.
module seq_detector_param #(
  parameter int                 SEQ_LEN         = 4,
  parameter logic [SEQ_LEN-1:0] DEFAULT_PATTERN = 4'b1001,
  parameter int                 CNT_W           = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_x,
  input  logic                         i_valid,
  input  logic                         i_overlap,
  input  logic                         i_load,
  input  logic [SEQ_LEN-1:0]           i_pattern,
  input  logic                         i_clear_count,
  output logic                         o_seq_detected,
  output logic [CNT_W-1:0]             o_match_count,
  output logic [$clog2(SEQ_LEN+1)-1:0] o_fill
);

  localparam int FW = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);

  logic [SEQ_LEN-1:0] history;
  logic [SEQ_LEN-1:0] pattern;
  logic [SEQ_LEN-1:0] nh;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      nf;
  logic               accept;
  logic               match;

  always_comb begin
    accept = i_valid & ~i_load;
    nh     = {history[SEQ_LEN-2:0], i_x};
    nf     = (fill == FULL) ? fill : fill + 1'b1;
    match  = accept && (nf == FULL) && (nh == pattern);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      history <= '0;
      fill    <= '0;
      pattern <= DEFAULT_PATTERN;
    end else if (i_load) begin
      history <= '0;
      fill    <= '0;
      pattern <= i_pattern;
    end else if (accept) begin
      history <= nh;
      // non-overlap demands a whole fresh window after a hit
      fill    <= (match && !i_overlap) ? '0 : nf;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_seq_detected <= 1'b0;
    end else begin
      o_seq_detected <= match;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_match_count <= '0;
    end else if (i_clear_count) begin
      o_match_count <= '0;
    end else if (match && (o_match_count != '1)) begin
      o_match_count <= o_match_count + 1'b1;
    end
  end

  assign o_fill = fill;

endmodule
